// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the 4-way, 32-set cache miss-handling logic.
// Used by cache_fill_fsm (top) and fill_victim_select (victim picker).
// No ports: package only.
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int NUM_WAYS        = 4;
    localparam int NUM_SETS        = 32;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_W          = 16;
    localparam int WI              = $clog2(WORDS_PER_BLOCK);
    localparam int LRU_W           = 2;

    // Fill controller states; also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAGWR = 2'd2
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm_if
// Bundles every signal between the fill controller and its neighbours
// (tag compare, main memory, LRU/tag/data arrays).
//   slave  modport : the fill controller itself
//   master modport : the environment driving misses and memory returns
//
// Handshake semantics (no backpressure anywhere):
//   miss_detected     - single-cycle valid; taken only while the controller is
//                       idle, otherwise dropped (no queuing).
//   mem_en            - read request valid; memory always accepts it, no ready.
//   memory_data_valid - one returned word per asserted cycle, in request order;
//                       returns may overlap outstanding requests.
//   write_data_array  - data array write valid; array always accepts.
//   write_tag_array   - one-cycle tag write / LRU update strobe.
// ----------------------------------------------------------------------------
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int WI     = 3
);
    // Environment -> controller
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic [3:0]        valid_ways;
    logic [1:0]        lru_0;
    logic [1:0]        lru_1;
    logic [1:0]        lru_2;
    logic [1:0]        lru_3;
    logic              memory_data_valid;
    logic [WORD_W-1:0] memory_data;

    // Controller -> environment
    logic              fsm_busy;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_address;
    logic              write_data_array;
    logic [WI-1:0]     data_word_sel;
    logic [WORD_W-1:0] fill_data;
    logic              write_tag_array;
    logic [3:0]        miss_way;

    modport slave (
        input  miss_detected, miss_address, valid_ways,
        input  lru_0, lru_1, lru_2, lru_3,
        input  memory_data_valid, memory_data,
        output fsm_busy, mem_en, mem_address, write_data_array,
        output data_word_sel, fill_data, write_tag_array, miss_way
    );

    modport master (
        output miss_detected, miss_address, valid_ways,
        output lru_0, lru_1, lru_2, lru_3,
        output memory_data_valid, memory_data,
        input  fsm_busy, mem_en, mem_address, write_data_array,
        input  data_word_sel, fill_data, write_tag_array, miss_way
    );

endinterface

// File: rtl/fill_victim_select.sv
// ----------------------------------------------------------------------------
// fill_victim_select
// Combinational victim-way picker shared by the instruction and data caches.
// Priority: lowest-index invalid way, else lowest-index way whose LRU counter
// is 00, else way 0.
// Ports:
//   valid_ways  in  valid bits of the indexed set (bit i = way i)
//   lru_0..3    in  LRU counters of the indexed set (00 = least recent)
//   victim      out one-hot victim way
// ----------------------------------------------------------------------------
module fill_victim_select
    import cache_pkg::*;
(
    input  logic [NUM_WAYS-1:0] valid_ways,
    input  logic [LRU_W-1:0]    lru_0,
    input  logic [LRU_W-1:0]    lru_1,
    input  logic [LRU_W-1:0]    lru_2,
    input  logic [LRU_W-1:0]    lru_3,
    output logic [NUM_WAYS-1:0] victim
);

    logic [NUM_WAYS-1:0] lru_zero;
    logic                found;

    always_comb begin
        lru_zero = {lru_3 == '0, lru_2 == '0, lru_1 == '0, lru_0 == '0};
        victim   = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!found && !valid_ways[i]) begin
                victim[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!found && lru_zero[i]) begin
                victim[i] = 1'b1;
                found     = 1'b1;
            end
        end
        if (!found) begin
            victim[0] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
// Miss handler: on an accepted miss picks a victim way, requests the whole
// block from memory (one word per cycle), writes each returned word into the
// data array, then issues a single tag-write / LRU-update strobe.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        cache_fill_fsm_if.slave (miss input, memory side, array writes)
//   state_dbg  current controller state for observation
// Build option:
//   CACHE_FILL_CRITICAL_WORD_EN - when defined, requests and returns start at
//   the missing word and wrap around the block; otherwise both start at word 0.
// ----------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int WORD_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_fill_fsm_if.slave        bus,
    output cache_pkg::fill_state_e state_dbg
);

    localparam int WI = $clog2(WORDS_PER_BLOCK);
    localparam logic [WI:0] FULL_CNT = (WI+1)'(WORDS_PER_BLOCK);
    localparam logic [WI:0] LAST_CNT = (WI+1)'(WORDS_PER_BLOCK - 1);

    cache_pkg::fill_state_e state_q, state_d;

    // Block base keeps only the bits above the byte-in-block offset.
    logic [ADDR_W-WI-2:0] base_q, base_d;
    logic [3:0]           way_q, way_d;
    logic [WI-1:0]        req_idx_q, req_idx_d;
    logic [WI-1:0]        ret_idx_q, ret_idx_d;
    logic [WI:0]          req_cnt_q, req_cnt_d;
    logic [WI:0]          ret_cnt_q, ret_cnt_d;

    logic [3:0]           victim_way;
    logic [WI-1:0]        start_idx;
    logic                 mem_en_w;
    logic                 wr_en_w;
    logic                 unused_addr_bits;

    fill_victim_select u_victim (
        .valid_ways (bus.valid_ways),
        .lru_0      (bus.lru_0),
        .lru_1      (bus.lru_1),
        .lru_2      (bus.lru_2),
        .lru_3      (bus.lru_3),
        .victim     (victim_way)
    );

`ifdef CACHE_FILL_CRITICAL_WORD_EN
    assign start_idx = bus.miss_address[WI:1];
`else
    assign start_idx = '0;
`endif

    // Byte-in-block offset bits are not needed in every build.
    assign unused_addr_bits = ^bus.miss_address[WI:0];

    // Requests stop once the full block has been asked for; returns are only
    // honoured while filling, so stray valids in IDLE/TAGWR are dropped.
    assign mem_en_w = (state_q == cache_pkg::FILL) && (req_cnt_q != FULL_CNT);
    assign wr_en_w  = (state_q == cache_pkg::FILL) && bus.memory_data_valid;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= cache_pkg::IDLE;
            base_q    <= '0;
            way_q     <= '0;
            req_idx_q <= '0;
            ret_idx_q <= '0;
            req_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            way_q     <= way_d;
            req_idx_q <= req_idx_d;
            ret_idx_q <= ret_idx_d;
            req_cnt_q <= req_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        way_d     = way_q;
        req_idx_d = req_idx_q;
        ret_idx_d = ret_idx_q;
        req_cnt_d = req_cnt_q;
        ret_cnt_d = ret_cnt_q;
        case (state_q)
            cache_pkg::IDLE: begin
                if (bus.miss_detected) begin
                    state_d   = cache_pkg::FILL;
                    base_d    = bus.miss_address[ADDR_W-1:WI+1];
                    way_d     = victim_way;
                    req_idx_d = start_idx;
                    ret_idx_d = start_idx;
                    req_cnt_d = '0;
                    ret_cnt_d = '0;
                end
            end
            cache_pkg::FILL: begin
                if (mem_en_w) begin
                    req_idx_d = req_idx_q + 1'b1;
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (wr_en_w) begin
                    ret_idx_d = ret_idx_q + 1'b1;
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == LAST_CNT) begin
                        state_d = cache_pkg::TAGWR;
                    end
                end
            end
            cache_pkg::TAGWR: begin
                state_d = cache_pkg::IDLE;
                way_d   = '0;
            end
            default: begin
                state_d = cache_pkg::IDLE;
                way_d   = '0;
            end
        endcase
    end

    // Outputs: everything is gated so that IDLE drives all zeros.
    always_comb begin
        bus.fsm_busy         = (state_q != cache_pkg::IDLE);
        bus.mem_en           = mem_en_w;
        bus.mem_address      = mem_en_w ? {base_q, req_idx_q, 1'b0} : '0;
        bus.write_data_array = wr_en_w;
        bus.data_word_sel    = wr_en_w ? ret_idx_q : '0;
        bus.fill_data        = wr_en_w ? bus.memory_data : '0;
        bus.write_tag_array  = (state_q == cache_pkg::TAGWR);
        bus.miss_way         = way_q;
        state_dbg            = state_q;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Directed bench for cache_fill_fsm with a 4-cycle-latency memory model.
// Memory returns (request address ^ 16'h5A5A) for each word.
// ----------------------------------------------------------------------------
module tb_cache_fill_fsm;
    import cache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_fsm_if #(.ADDR_W(16), .WORD_W(16), .WI(3)) bus ();
    fill_state_e state_dbg;

    cache_fill_fsm #(
        .ADDR_W          (16),
        .WORDS_PER_BLOCK (8),
        .WORD_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        nxt_miss    = 1'b0;
    logic        nxt_rst     = 1'b1;
    logic        extra_valid = 1'b0;
    logic [3:0]  vpipe       = '0;
    logic [15:0] apipe [4];

    // observations
    logic [15:0] addr_obs[$];
    logic [18:0] wr_obs[$];
    int          mem_cnt, tag_cnt, busy_cnt, tag_cyc, way_err;
    logic [3:0]  first_way, exp_way;
    bit          seen_busy;

    // scoreboard expectations
    logic [15:0] exp_addr_q[$];
    logic [18:0] exp_wr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        addr_obs.delete();
        wr_obs.delete();
        exp_addr_q.delete();
        exp_wr_q.delete();
        mem_cnt   = 0;
        tag_cnt   = 0;
        busy_cnt  = 0;
        tag_cyc   = -1;
        way_err   = 0;
        first_way = '0;
        seen_busy = 1'b0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Inputs for the cycle are applied just after the rising edge, outputs are
    // sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst                   = nxt_rst;
        bus.miss_detected     = nxt_miss;
        bus.memory_data_valid = vpipe[3] | extra_valid;
        bus.memory_data       = vpipe[3] ? (apipe[3] ^ 16'h5A5A) : 16'h0000;
        @(negedge clk);
        if (bus.mem_en) begin
            mem_cnt++;
            addr_obs.push_back(bus.mem_address);
        end
        if (bus.write_data_array) wr_obs.push_back({bus.data_word_sel, bus.fill_data});
        if (bus.write_tag_array) begin
            tag_cnt++;
            tag_cyc = cyc;
        end
        if (bus.fsm_busy) begin
            busy_cnt++;
            if (!seen_busy) first_way = bus.miss_way;
            seen_busy = 1'b1;
            if (bus.miss_way !== exp_way) way_err++;
        end
        vpipe    = {vpipe[2:0], bus.mem_en};
        apipe[3] = apipe[2];
        apipe[2] = apipe[1];
        apipe[1] = apipe[0];
        apipe[0] = bus.mem_address;
    endtask

    // ---------------- one full fill ----------------
    task automatic run_fill(input string name, input logic [15:0] addr, input logic [3:0] vw,
                            input logic [1:0] l0, input logic [1:0] l1, input logic [1:0] l2,
                            input logic [1:0] l3, input logic [3:0] way, input bit disturb);
        int          t0;
        int          start;
        bit          done;
        logic [2:0]  idx;
        logic [15:0] base;
        logic [15:0] a;
        clear_obs();
        exp_way = way;
        done    = 1'b0;
        bus.miss_address = addr;
        bus.valid_ways   = vw;
        bus.lru_0 = l0;
        bus.lru_1 = l1;
        bus.lru_2 = l2;
        bus.lru_3 = l3;
        nxt_miss = 1'b1;
        step();
        t0 = cyc;
        nxt_miss = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (disturb && cyc == t0 + 2) begin
                nxt_miss         = 1'b1;
                bus.miss_address = addr ^ 16'h0F00;
                bus.valid_ways   = 4'b0000;
            end
            if (disturb && cyc == t0 + 12) extra_valid = 1'b1;
            step();
            nxt_miss    = 1'b0;
            extra_valid = 1'b0;
            if (state_dbg == IDLE) done = 1'b1;
        end

        // model
`ifdef CACHE_FILL_CRITICAL_WORD_EN
        start = int'(addr[3:1]);
`else
        start = 0;
`endif
        base = {addr[15:4], 4'h0};
        for (int i = 0; i < 8; i++) begin
            idx = 3'((start + i) % 8);
            a   = base + {12'h000, idx, 1'b0};
            exp_addr_q.push_back(a);
            exp_wr_q.push_back({idx, a ^ 16'h5A5A});
        end

        check({name, "_idle_at"}, cyc - t0, 14);
        check({name, "_way"}, first_way, way);
        check({name, "_way_held"}, way_err, 0);
        check({name, "_busy_cycles"}, busy_cnt, 13);
        check({name, "_mem_en_cnt"}, mem_cnt, 8);
        check({name, "_tag_cnt"}, tag_cnt, 1);
        check({name, "_tag_at"}, tag_cyc - t0, 13);
        check({name, "_wr_cnt"}, wr_obs.size(), 8);
        check({name, "_way_idle"}, bus.miss_way, 0);
        for (int i = 0; i < 8; i++) begin
            if (addr_obs.size() > 0) check({name, "_addr"}, addr_obs.pop_front(), exp_addr_q.pop_front());
            if (wr_obs.size() > 0) check({name, "_wr"}, wr_obs.pop_front(), exp_wr_q.pop_front());
        end
    endtask

    // ---------------- reset during fill ----------------
    task automatic run_reset_abort();
        int t0;
        clear_obs();
        exp_way = 4'b0001;
        bus.miss_address = 16'h2468;
        bus.valid_ways   = 4'b1111;
        bus.lru_0 = 2'd1;
        bus.lru_1 = 2'd1;
        bus.lru_2 = 2'd2;
        bus.lru_3 = 2'd3;
        nxt_miss = 1'b1;
        step();
        t0 = cyc;
        nxt_miss = 1'b0;
        repeat (5) step();
        nxt_rst = 1'b1;
        step();
        check("rst_t6_still_busy", bus.fsm_busy, 1);
        nxt_rst = 1'b0;
        step();
        check("rst_t7_cycle", cyc - t0, 7);
        check("rst_state", state_dbg, IDLE);
        check("rst_busy", bus.fsm_busy, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_wr", bus.write_data_array, 0);
        check("rst_sel", bus.data_word_sel, 0);
        check("rst_fill_data", bus.fill_data, 0);
        check("rst_tag", bus.write_tag_array, 0);
        check("rst_way", bus.miss_way, 0);
        repeat (12) step();
        check("rst_no_tag", tag_cnt, 0);
        check("rst_mem_en_cnt", mem_cnt, 6);
        check("rst_wr_cnt", wr_obs.size(), 2);
        check("rst_way_before", first_way, 4'b0001);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.valid_ways        = '0;
        bus.lru_0             = '0;
        bus.lru_1             = '0;
        bus.lru_2             = '0;
        bus.lru_3             = '0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = '0;
        for (int i = 0; i < 4; i++) apipe[i] = '0;
        clear_obs();
        exp_way = '0;

        nxt_rst = 1'b1;
        repeat (3) step();
        check("reset_state", state_dbg, IDLE);
        check("reset_busy", bus.fsm_busy, 0);
        check("reset_mem_en", bus.mem_en, 0);
        check("reset_tag", bus.write_tag_array, 0);
        check("reset_way", bus.miss_way, 0);
        nxt_rst = 1'b0;
        step();

        // memory return while idle must not write
        extra_valid = 1'b1;
        step();
        extra_valid = 1'b0;
        check("idle_valid_no_write", bus.write_data_array, 0);
        check("idle_valid_busy", bus.fsm_busy, 0);
        step();

        run_fill("a1234", 16'h1234, 4'b1111, 2'd3, 2'd2, 2'd0, 2'd1, 4'b0100, 1'b0);
        run_fill("v1011", 16'h0040, 4'b1011, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0100, 1'b1);
        run_fill("v0000", 16'hFFFE, 4'b0000, 2'd3, 2'd3, 2'd3, 2'd3, 4'b0001, 1'b0);
        run_fill("lru00", 16'h0100, 4'b1111, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0);
        run_fill("a100a", 16'h100A, 4'b1111, 2'd1, 2'd2, 2'd3, 2'd0, 4'b1000, 1'b0);
        run_fill("nolru0", 16'h3456, 4'b1111, 2'd1, 2'd1, 2'd2, 2'd3, 4'b0001, 1'b0);
        run_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss handler for the 4-way, 32-set cache.
- On a miss it picks the victim way from the per-set LRU counters and valid bits, then fetches the 8-word block from memory.
- Each returned word is written into the data array; the cycle-final tag write strobes the LRU superfile's cache_tag_write with a one-hot miss_way.
- Sits between cache tag-compare logic, main memory and the LRU/tag/data arrays.

Parameters:
ADDR_W, 16, byte address width
WORDS_PER_BLOCK, 8, 16-bit words per block (power of two; word index width WI = log2)
WORD_W, 16, data word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
miss_detected  in  1  tag compare missed this cycle
miss_address  in  ADDR_W  byte address of missing access
valid_ways  in  4  valid bits of the indexed set, bit i = way i
lru_0..lru_3  in  2 each  LRU counters of the indexed set (00 = least recent)
memory_data_valid  in  1  memory returns one word this cycle
memory_data  in  WORD_W  returned word
fsm_busy  out  1  fill in progress; pipeline stalls
mem_en  out  1  memory read request this cycle
mem_address  out  ADDR_W  read address
write_data_array  out  1  write fill_data into data array
data_word_sel  out  WI  word slot being written
fill_data  out  WORD_W  word to write (memory_data, registered path not required)
write_tag_array  out  1  tag write / LRU update strobe (drives cache_tag_write)
miss_way  out  4  one-hot victim way, held throughout fill

Behaviour:
- States: IDLE, FILL, TAGWR.
- Reset: state IDLE; all outputs 0; counters 0; rst mid-fill aborts immediately, no tag write issued.
- IDLE: miss_detected=1 at cycle T latches block base (miss_address with low log2(2*WORDS_PER_BLOCK) bits cleared), victim and start word; FILL at T+1. No response to memory_data_valid in IDLE.
- Victim select, evaluated only at acceptance:
  - lowest-index invalid way;
  - else lowest-index way with lru_i==00;
  - else way 0.
- FILL request side:
  - mem_en=1 for exactly WORDS_PER_BLOCK consecutive cycles (T+1..T+8).
  - mem_address = base + 2*req_idx; req_idx increments per request, wraps modulo WORDS_PER_BLOCK.
- FILL return side:
  - each memory_data_valid cycle → write_data_array=1, data_word_sel=ret_idx, fill_data=memory_data; ret_idx then increments modulo block.
  - Requests and returns overlap; returns may arrive while requests are still issuing.
- FILL exit: after the WORDS_PER_BLOCK-th return, TAGWR next cycle.
- TAGWR: write_tag_array=1 for exactly one cycle with miss_way valid, then IDLE.
- fsm_busy = (state != IDLE); high from T+1 through the TAGWR cycle inclusive.
- miss_detected while busy: ignored, no queuing.
- Extra memory_data_valid after the final word: ignored.
- miss_way = 0 in IDLE; constant one-hot during FILL/TAGWR.
- With a 4-cycle memory: first return T+5, last T+12, TAGWR T+13, IDLE T+14.

Optional Feature:
CACHE_FILL_CRITICAL_WORD_EN
- Defined: request and return sequences start at the missing word index (miss_address[WI:1]) and wrap modulo WORDS_PER_BLOCK.
- Undefined: both sequences start at word 0.
- Handshake and latency are identical either way.

Decomposition:
- Shared package cache_pkg: state enum (IDLE/FILL/TAGWR), NUM_WAYS=4, NUM_SETS=32, WORDS_PER_BLOCK, WORD_W, WI, LRU_W=2.
- One sub-module: fill_victim_select (valid_ways + lru_0..3 → one-hot way), reused by the instruction and data caches.

Test Plan:
- Miss at 0x1234, all valid, lru={3,2,0,1} → miss_way=0100; mem_address 0x1230..0x123E; 8 data writes with sel 0..7; write_tag_array one cycle at T+13.
- valid_ways=1011 with any lru → miss_way=0100; valid_ways=0000 → 0001.
- All valid, lru all 00 (post-reset) → miss_way=0001.
- Second miss_detected pulse during FILL → ignored; exactly one TAGWR; mem_en count stays 8.
- rst asserted at T+6 → next cycle all outputs 0, IDLE, no write_tag_array ever seen.
- With CACHE_FILL_CRITICAL_WORD_EN, miss at 0x100A → addresses 0x100A,0x100C,0x100E,0x1000..0x1008; sel 5,6,7,0..4.
